seg7_bin2bcd_feeder: RTL and testbench

//  Upstream feeder for the 8-digit seven-segment display stage.
//  - Accepts a binary value and converts it to packed BCD with a sequential double-dabble algorithm.
//  - Drives the display's 32-bit digit bus and its one-cycle write strobe.
//  - Lets software or a counter write plain binary and see it shown in decimal.

---
 rtl/seg7_pkg.sv | 23 ++
 rtl/seg7_bcd_adj3.sv | 15 +
 rtl/seg7_bin2bcd_feeder.sv | 117 +++++++++++
 tb/tb_seg7_bin2bcd_feeder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment feeder: FSM state encoding,
// BCD nibble width and the largest value representable in N decimal digits.
package seg7_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } seg7State_t;

  // 10^digits - 1, evaluated at elaboration time to size the clamp constant.
  function automatic longint unsigned max_dec(input int digits);
    longint unsigned acc;
    acc = 64'd1;
    for (int i = 0; i < digits; i++) begin
      acc = acc * 64'd10;
    end
    return acc - 64'd1;
  endfunction

endpackage

// File: rtl/seg7_bcd_adj3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
module seg7_bcd_adj3
  import seg7_pkg::*;
(
  input  logic [NIBBLE_W-1:0] digit,
  output logic [NIBBLE_W-1:0] adjusted
);

  // Add-3 correction; input is at most 9 so the result never wraps.
  always_comb begin
    adjusted = (digit >= 4'd5) ? (digit + 4'd3) : digit;
  end

endmodule

// File: rtl/seg7_bin2bcd_feeder.sv
// Binary-to-packed-BCD converter feeding the 8-digit seven-segment display.
// A start request latches a clamped copy of the binary input, runs one
// double-dabble iteration per clock and then presents the full BCD word
// together with a single-cycle write strobe.
module seg7_bin2bcd_feeder
  import seg7_pkg::*;
#(
  parameter int BIN_W  = 27,
  parameter int DIGITS = 8
) (
  input  logic                         iCLK,
  input  logic                         iRST_N,
  input  logic                         iSTART,
  input  logic [BIN_W-1:0]             iBIN,
  output logic [NIBBLE_W*DIGITS-1:0]   oDIG,
  output logic                         oWR,
  output logic                         oBUSY,
  output logic                         oOVF
);

  localparam int BCD_W = NIBBLE_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [BIN_W-1:0] MAX_VAL = BIN_W'(max_dec(DIGITS));
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  seg7State_t        state;
  seg7State_t        stateNext;
  logic              loadSrc;
  logic              overIn;
  logic [BIN_W-1:0]  srcReg;
  logic [BCD_W-1:0]  bcdReg;
  logic [BCD_W-1:0]  bcdAdj;
  logic [CNT_W-1:0]  cnt;

  assign overIn = (iBIN > MAX_VAL);

  // One add-3 corrector per decimal digit of the accumulator.
  for (genvar g = 0; g < DIGITS; g++) begin : gAdj
    seg7_bcd_adj3 uAdj (
      .digit    (bcdReg[g*NIBBLE_W +: NIBBLE_W]),
      .adjusted (bcdAdj[g*NIBBLE_W +: NIBBLE_W])
    );
  end

  // State register; reset drops any conversion in flight.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic: IDLE waits for a start, CONV runs BIN_W iterations,
  // DONE publishes the result for one cycle.
  always_comb begin
    stateNext = state;
    loadSrc   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (iSTART) begin
          loadSrc   = 1'b1;
          stateNext = ST_CONV;
        end
      end
      ST_CONV: begin
        if (cnt == LAST_CNT) begin
          stateNext = ST_DONE;
        end
      end
      ST_DONE: begin
        stateNext = ST_IDLE;
      end
      default: begin
        stateNext = ST_IDLE;
      end
    endcase
  end

  // Shift registers and iteration counter: latch the clamped source on
  // start, then correct-and-shift {bcd,src} once per CONV cycle.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      srcReg <= '0;
      bcdReg <= '0;
      cnt    <= '0;
    end else if (loadSrc) begin
      srcReg <= overIn ? MAX_VAL : iBIN;
      bcdReg <= '0;
      cnt    <= '0;
    end else if (state == ST_CONV) begin
      {bcdReg, srcReg} <= {bcdAdj, srcReg} << 1;
      cnt              <= cnt + 1'b1;
    end
  end

  // Output registers: oDIG only updates from a finished conversion, so the
  // display never sees intermediate accumulator contents.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oDIG  <= '0;
      oWR   <= 1'b0;
      oBUSY <= 1'b0;
      oOVF  <= 1'b0;
    end else begin
      oWR   <= (state == ST_DONE);
      oBUSY <= (stateNext != ST_IDLE);
      if (state == ST_DONE) begin
        oDIG <= bcdReg;
      end
      if (loadSrc) begin
        oOVF <= overIn;
      end
    end
  end

endmodule

// File: tb/tb_seg7_bin2bcd_feeder.sv
// Directed bench for the binary-to-BCD display feeder.
module tb_seg7_bin2bcd_feeder;

  localparam int BIN_W  = 27;
  localparam int DIGITS = 8;
  localparam int LAT    = BIN_W + 1;
  localparam int PERIOD = BIN_W + 2;

  logic              iCLK;
  logic              iRST_N;
  logic              iSTART;
  logic [BIN_W-1:0]  iBIN;
  logic [31:0]       oDIG;
  logic              oWR;
  logic              oBUSY;
  logic              oOVF;

  int checks;
  int failures;
  int wrCount;
  int cyc;

  seg7_bin2bcd_feeder #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .iSTART (iSTART),
    .iBIN   (iBIN),
    .oDIG   (oDIG),
    .oWR    (oWR),
    .oBUSY  (oBUSY),
    .oOVF   (oOVF)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) cyc = cyc + 1;
  always @(negedge iCLK) if (oWR) wrCount = wrCount + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Decimal reference: digit-by-digit division, independent of double-dabble.
  function automatic logic [31:0] toBcd(input longint unsigned v);
    logic [31:0] r;
    longint unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Pulse iSTART with value v; returns just after the sampling edge.
  task automatic startPulse(input logic [BIN_W-1:0] v);
    @(negedge iCLK);
    iBIN   = v;
    iSTART = 1'b1;
    @(posedge iCLK);
    #1;
    iSTART = 1'b0;
  endtask

  // Wait up to 40 edges for oWR; lat = edges waited, or -1 on timeout.
  task automatic waitWr(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge iCLK);
      #1;
      if (oWR) begin
        lat = i;
        return;
      end
    end
  endtask

  task automatic convCheck(input string tag, input logic [BIN_W-1:0] v,
                           input logic [31:0] expDig, input logic expOvf);
    int lat;
    startPulse(v);
    checkVal({tag, "_busy"}, 64'(oBUSY), 64'd1);
    iBIN = ~v;
    waitWr(lat);
    checkVal({tag, "_lat"}, 64'(lat), 64'(LAT));
    checkVal({tag, "_dig"}, 64'(oDIG), 64'(expDig));
    checkVal({tag, "_ovf"}, 64'(oOVF), 64'(expOvf));
    @(posedge iCLK);
    #1;
    checkVal({tag, "_wrlow"}, 64'(oWR), 64'd0);
    checkVal({tag, "_idle"}, 64'(oBUSY), 64'd0);
    checkVal({tag, "_hold"}, 64'(oDIG), 64'(expDig));
  endtask

  initial begin
    int lat;
    int wrBefore;
    int lastCyc;
    logic [BIN_W-1:0] v;
    logic [BIN_W-1:0] nextV;
    logic [31:0] expDig;
    logic expOvf;

    checks   = 0;
    failures = 0;
    wrCount  = 0;
    cyc      = 0;
    iRST_N   = 1'b0;
    iSTART   = 1'b0;
    iBIN     = '0;

    repeat (3) @(posedge iCLK);
    #1;
    checkVal("rst_dig",  64'(oDIG),  64'd0);
    checkVal("rst_wr",   64'(oWR),   64'd0);
    checkVal("rst_busy", 64'(oBUSY), 64'd0);
    checkVal("rst_ovf",  64'(oOVF),  64'd0);
    @(negedge iCLK);
    iRST_N = 1'b1;

    convCheck("t1",    27'd12_345_678, 32'h1234_5678, 1'b0);
    convCheck("zero",  27'd0,          32'h0000_0000, 1'b0);
    convCheck("nines", 27'd99_999_999, 32'h9999_9999, 1'b0);
    convCheck("ovf1",  27'd100_000_000, 32'h9999_9999, 1'b1);
    convCheck("ovfmax", 27'h7FF_FFFF,  32'h9999_9999, 1'b1);
    convCheck("small", 27'd1234,       32'h0000_1234, 1'b0);

    // Start while busy is ignored.
    wrBefore = wrCount;
    startPulse(27'd1234);
    repeat (9) @(posedge iCLK);
    @(negedge iCLK);
    iBIN   = 27'd5678;
    iSTART = 1'b1;
    @(posedge iCLK);
    #1;
    iSTART = 1'b0;
    waitWr(lat);
    checkVal("busy_lat", 64'(lat), 64'(LAT - 10));
    checkVal("busy_dig", 64'(oDIG), 64'h0000_1234);
    repeat (40) @(posedge iCLK);
    #1;
    checkVal("busy_single_wr", 64'(wrCount - wrBefore), 64'd1);
    checkVal("busy_idle", 64'(oBUSY), 64'd0);

    // Reset mid-conversion; oOVF and oDIG are nonzero beforehand.
    startPulse(27'd120_000_000);
    repeat (14) @(posedge iCLK);
    #1;
    checkVal("abort_pre_ovf", 64'(oOVF), 64'd1);
    wrBefore = wrCount;
    @(negedge iCLK);
    iRST_N = 1'b0;
    #1;
    checkVal("abort_dig",  64'(oDIG),  64'd0);
    checkVal("abort_wr",   64'(oWR),   64'd0);
    checkVal("abort_busy", 64'(oBUSY), 64'd0);
    checkVal("abort_ovf",  64'(oOVF),  64'd0);
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    iRST_N = 1'b1;
    repeat (40) @(posedge iCLK);
    #1;
    checkVal("abort_no_wr", 64'(wrCount - wrBefore), 64'd0);
    convCheck("after_rst", 27'd87_654_321, 32'h8765_4321, 1'b0);

    // Back-to-back: restart in every strobe cycle.
    v = 27'($urandom_range(0, 99_999_999));
    startPulse(v);
    lastCyc = -1;
    for (int n = 0; n < 1000; n++) begin
      waitWr(lat);
      if (lat < 0) begin
        checkVal("b2b_timeout", 64'(lat), 64'(LAT));
        break;
      end
      expOvf = (v > 27'd99_999_999);
      expDig = expOvf ? 32'h9999_9999 : toBcd(64'(v));
      checkVal("b2b_dig", 64'(oDIG), 64'(expDig));
      checkVal("b2b_ovf", 64'(oOVF), 64'(expOvf));
      if (lastCyc >= 0) begin
        checkVal("b2b_spacing", 64'(cyc - lastCyc), 64'(PERIOD));
      end
      lastCyc = cyc;
      if (n < 999) begin
        if (n % 50 == 49) nextV = 27'($urandom_range(100_000_000, 134_217_727));
        else              nextV = 27'($urandom_range(0, 99_999_999));
        iBIN   = nextV;
        iSTART = 1'b1;
        @(posedge iCLK);
        #1;
        iSTART = 1'b0;
        iBIN   = ~nextV;
        v      = nextV;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
